test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 150 +++++++++++++++
 tb/tb_test_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// Test sequencer: resets, starts and runs a core, then scans its register file against expected data (TEST_SEQ_MASK_EN adds exp_mask).
// Latency: done rises on the RESET_CYCLES+1+TEST_LENGTH+NUM_REGS+1'th rising edge counting the edge that accepts go.
// Backpressure: none; go is only accepted in IDLE or DONE and ignored while busy.
module test_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int IDX_BITS     = 5,
    parameter int ADDRESS_BITS = 12,
    parameter int RESET_CYCLES = 6,
    parameter int TEST_LENGTH  = 100
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    go,
    input  logic [ADDRESS_BITS-1:0] prog_address_in,
    output logic                    core_reset,
    output logic                    core_start,
    output logic [ADDRESS_BITS-1:0] core_prog_address,
    output logic [IDX_BITS-1:0]     rf_sel,
    input  logic [DATA_WIDTH-1:0]   rf_data,
    input  logic [DATA_WIDTH-1:0]   exp_data,
`ifdef TEST_SEQ_MASK_EN
    input  logic [DATA_WIDTH-1:0]   exp_mask,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    passed,
    output logic [IDX_BITS:0]       mismatch_count,
    output logic [IDX_BITS-1:0]     first_fail_idx,
    output logic                    first_fail_valid
);

    localparam int CNT_MAX = (RESET_CYCLES > TEST_LENGTH) ? RESET_CYCLES : TEST_LENGTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]    RUN_LAST  = CNT_W'(TEST_LENGTH - 1);
    localparam logic [IDX_BITS-1:0] LAST_SEL  = IDX_BITS'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, HOLD, START, RUN, SCAN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_BITS-1:0]     sel_q, sel_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [IDX_BITS:0]       mcnt_q, mcnt_d;
    logic [IDX_BITS-1:0]     ffidx_q, ffidx_d;
    logic                    ffvld_q, ffvld_d;
    logic [DATA_WIDTH-1:0]   diff;
    logic                    mismatch;

    always_comb begin
        diff = rf_data ^ exp_data;
`ifdef TEST_SEQ_MASK_EN
        diff = diff & exp_mask;
`endif
        mismatch = |diff;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        mcnt_d  = mcnt_q;
        ffidx_d = ffidx_q;
        ffvld_d = ffvld_q;
        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    addr_d  = prog_address_in;
                    mcnt_d  = '0;
                    ffidx_d = '0;
                    ffvld_d = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            START: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (cnt_q == RUN_LAST) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    sel_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SCAN: begin
                // Only the first mismatch of a run pins the fail index.
                if (mismatch) begin
                    mcnt_d = mcnt_q + (IDX_BITS+1)'(1);
                    if (!ffvld_q) begin
                        ffidx_d = sel_q;
                        ffvld_d = 1'b1;
                    end
                end
                if (sel_q == LAST_SEL) begin
                    state_d = DONE;
                    sel_d   = '0;
                end else begin
                    sel_d = sel_q + IDX_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            mcnt_q  <= '0;
            ffidx_q <= '0;
            ffvld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            mcnt_q  <= mcnt_d;
            ffidx_q <= ffidx_d;
            ffvld_q <= ffvld_d;
        end
    end

    assign core_reset        = (state_q == IDLE) || (state_q == HOLD) || (state_q == DONE);
    assign core_start        = (state_q == START);
    assign core_prog_address = addr_q;
    assign rf_sel            = sel_q;
    assign busy              = (state_q != IDLE) && (state_q != DONE);
    assign done              = (state_q == DONE);
    assign passed            = done && (mcnt_q == '0);
    assign mismatch_count    = mcnt_q;
    assign first_fail_idx    = ffidx_q;
    assign first_fail_valid  = ffvld_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Randomised bench for test_sequencer: register-file contents come from arrays, results are checked against a count-based reference.
module tb_test_sequencer;

    localparam int DW   = 32;
    localparam int NR   = 32;
    localparam int IB   = 5;
    localparam int AB   = 12;
    localparam int RC   = 6;
    localparam int TL   = 100;
    localparam int LAT  = RC + 1 + TL + NR + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          go    = 1'b0;
    logic [AB-1:0] prog_address_in = '0;
    logic          core_reset, core_start;
    logic [AB-1:0] core_prog_address;
    logic [IB-1:0] rf_sel;
    logic [DW-1:0] rf_data, exp_data;
    logic          busy, done, passed, first_fail_valid;
    logic [IB:0]   mismatch_count;
    logic [IB-1:0] first_fail_idx;

    logic [DW-1:0] rf_mem  [NR];
    logic [DW-1:0] exp_mem [NR];
`ifdef TEST_SEQ_MASK_EN
    logic [DW-1:0] mask_mem [NR];
    logic [DW-1:0] exp_mask;
    assign exp_mask = mask_mem[rf_sel];
`endif

    assign rf_data  = rf_mem[rf_sel];
    assign exp_data = exp_mem[rf_sel];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    test_sequencer #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .IDX_BITS(IB), .ADDRESS_BITS(AB),
        .RESET_CYCLES(RC), .TEST_LENGTH(TL)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .prog_address_in(prog_address_in),
        .core_reset(core_reset), .core_start(core_start), .core_prog_address(core_prog_address),
        .rf_sel(rf_sel), .rf_data(rf_data), .exp_data(exp_data),
`ifdef TEST_SEQ_MASK_EN
        .exp_mask(exp_mask),
`endif
        .busy(busy), .done(done), .passed(passed), .mismatch_count(mismatch_count),
        .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: a register fails when any compared bit differs; lowest failing index wins.
    task automatic model(output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int i = 0; i < NR; i++) begin
            logic [DW-1:0] d;
            d = rf_mem[i] ^ exp_mem[i];
`ifdef TEST_SEQ_MASK_EN
            d = d & mask_mem[i];
`endif
            if (d != '0) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_core_reset"}, core_reset, 1);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_addr"}, core_prog_address, 0);
        chk({tag, "_rf_sel"}, rf_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_passed"}, passed, 0);
        chk({tag, "_mcount"}, mismatch_count, 0);
        chk({tag, "_ffidx"}, first_fail_idx, 0);
        chk({tag, "_ffvalid"}, first_fail_valid, 0);
    endtask

    // Fill arrays: matching data, then flip one random bit in each register chosen with probability pct%.
    task automatic fill(input int pct);
        for (int i = 0; i < NR; i++) begin
            rf_mem[i]  = $urandom;
            exp_mem[i] = rf_mem[i];
`ifdef TEST_SEQ_MASK_EN
            mask_mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : '1;
`endif
            if ($urandom_range(0, 99) < pct)
                exp_mem[i][$urandom_range(0, DW-1)] ^= 1'b1;
        end
    endtask

    // Edge count n=1 is the edge that accepts go; go_mid_at/rst_at act at the negedge after edge n.
    task automatic run(input string tag, input int go_mid_at, input int rst_at);
        int n, start_at, start_cnt, rst_low, busy_low, exp_cnt, exp_first;
        logic [AB-1:0] addr;
        addr = AB'($urandom);
        model(exp_cnt, exp_first);
        n = 0; start_at = -1; start_cnt = 0; rst_low = 0; busy_low = 0;
        @(negedge clock);
        prog_address_in = addr;
        go = 1'b1;
        while (n < 1000) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            go = (n == go_mid_at);
            prog_address_in = AB'($urandom);
            if (n == rst_at) begin
                reset = 1'b0;
                #1;
                check_reset_vals({tag, "_midrst"});
                #1;
                reset = 1'b1;
                return;
            end
            if (done) break;
            if (core_start) begin start_cnt++; start_at = n; end
            if (!core_reset) rst_low++;
            if (!busy) busy_low++;
        end
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_start_edge"}, start_at, RC + 1);
        chk({tag, "_start_pulses"}, start_cnt, 1);
        chk({tag, "_core_run_cycles"}, rst_low, 1 + TL + NR);
        chk({tag, "_busy_gaps"}, busy_low, 0);
        repeat (5) @(negedge clock);
        chk({tag, "_done_hold"}, done, 1);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_core_reset_done"}, core_reset, 1);
        chk({tag, "_addr"}, core_prog_address, addr);
        chk({tag, "_passed"}, passed, exp_cnt == 0);
        chk({tag, "_mcount"}, mismatch_count, exp_cnt);
        chk({tag, "_ffvalid"}, first_fail_valid, exp_cnt != 0);
        chk({tag, "_ffidx"}, first_fail_idx, exp_first);
    endtask

    initial begin
        #1;
        check_reset_vals("por");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("idle");

        fill(0);
        rf_mem[1] = 32'h0000_1000; exp_mem[1] = 32'h0000_1000;
        rf_mem[2] = 32'h8000_0000; exp_mem[2] = 32'h8000_0000;
        run("all_match", -1, -1);

        fill(0);
        exp_mem[13] = ~rf_mem[13];
        exp_mem[20] = rf_mem[20] ^ 32'h0000_0001;
`ifdef TEST_SEQ_MASK_EN
        mask_mem[13] = '1;
        mask_mem[20] = '1;
`endif
        run("regs_13_20", -1, -1);

        fill(30);
        run("go_in_run", 50, -1);

        fill(0);
        exp_mem[3] = ~rf_mem[3];
`ifdef TEST_SEQ_MASK_EN
        mask_mem[3] = '1;
`endif
        run("rst_in_scan", -1, 120);
        run("after_rst", -1, -1);

        fill(0);
        exp_mem[0] = ~rf_mem[0];
        exp_mem[NR-1] = ~rf_mem[NR-1];
`ifdef TEST_SEQ_MASK_EN
        mask_mem[0] = '1;
        mask_mem[NR-1] = '1;
`endif
        run("edge_regs", -1, -1);

        for (int k = 0; k < 5; k++) begin
            fill($urandom_range(5, 90));
            run($sformatf("rand%0d", k), -1, -1);
        end

`ifdef TEST_SEQ_MASK_EN
        fill(0);
        for (int i = 0; i < NR; i++) mask_mem[i] = '1;
        rf_mem[7] = 32'h8000_0001; exp_mem[7] = 32'h8000_0000; mask_mem[7] = 32'hFFFF_FFFE;
        run("mask_lsb_off", -1, -1);
        mask_mem[7] = 32'hFFFF_FFFF;
        run("mask_all_on", -1, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
